// File: rtl/cordic_angle_sweeper.sv
// rtl/cordic_angle_sweeper.sv - angle sequence source for cordic_sin_cos, Q16.4 degrees wrapped to [-180,+180)
// Optional reverse sweeping via CORDIC_SWEEP_BIDIR_EN (adds dir port).
module cordic_angle_sweeper #(
  parameter int ANGLE_W    = 20,
  parameter int CNT_W      = 16,
  parameter int CORDIC_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
`ifdef CORDIC_SWEEP_BIDIR_EN
  input  logic               dir,
`endif
  input  logic [ANGLE_W-1:0] start_angle,
  input  logic [ANGLE_W-1:0] step,
  input  logic [CNT_W-1:0]   num_samples,
  output logic [ANGLE_W-1:0] target_angle,
  output logic               angle_valid,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DW = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;

  localparam logic signed [ANGLE_W:0] HALF_TURN = (ANGLE_W+1)'(2880);
  localparam logic signed [ANGLE_W:0] FULL_TURN = (ANGLE_W+1)'(5760);
  localparam logic [ANGLE_W-1:0]      STEP_MAX  = ANGLE_W'(5759);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  continuous;
  logic [ANGLE_W-1:0]    step_r;
  logic [DW-1:0]         drain_cnt;
  logic [CORDIC_LAT-1:0] sv_pipe;
  logic                  dir_r;
  logic                  start_go;
  logic                  last_angle;
  logic [ANGLE_W-1:0]    step_sat;

  logic signed [ANGLE_W:0] start_ext;
  logic signed [ANGLE_W:0] start_wrapped;
  logic signed [ANGLE_W:0] cur_ext;
  logic signed [ANGLE_W:0] step_ext;
  logic signed [ANGLE_W:0] sum_up;
  logic signed [ANGLE_W:0] sum_dn;
  logic signed [ANGLE_W:0] next_angle;

  assign start_go   = (state == S_IDLE) && start && !stop;
  assign step_sat   = (step > STEP_MAX) ? STEP_MAX : step;
  // Only a presented angle can be the last one; continuous mode never terminates on count.
  assign last_angle = angle_valid && !continuous && (cnt == CNT_W'(1));

  assign busy         = (state == S_RUN) || (state == S_DRAIN);
  assign done         = (state == S_DONE);
  assign sample_valid = sv_pipe[CORDIC_LAT-1];

  always_comb begin
    start_ext = {start_angle[ANGLE_W-1], start_angle};
    if (start_ext >= HALF_TURN)
      start_wrapped = start_ext - FULL_TURN;
    else if (start_ext < -HALF_TURN)
      start_wrapped = start_ext + FULL_TURN;
    else
      start_wrapped = start_ext;

    cur_ext  = {target_angle[ANGLE_W-1], target_angle};
    step_ext = {1'b0, step_r};
    sum_up   = cur_ext + step_ext;
    if (sum_up >= HALF_TURN)
      sum_up = sum_up - FULL_TURN;
    sum_dn   = cur_ext - step_ext;
    if (sum_dn < -HALF_TURN)
      sum_dn = sum_dn + FULL_TURN;
    next_angle = dir_r ? sum_dn : sum_up;
  end

`ifdef CORDIC_SWEEP_BIDIR_EN
  always_ff @(posedge clk) begin
    if (rst)
      dir_r <= 1'b0;
    else if (start_go)
      dir_r <= dir;
  end
`else
  assign dir_r = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      continuous   <= 1'b0;
      step_r       <= '0;
      drain_cnt    <= '0;
      sv_pipe      <= '0;
      target_angle <= '0;
      angle_valid  <= 1'b0;
    end else begin
      sv_pipe[0] <= angle_valid;
      for (int i = 1; i < CORDIC_LAT; i++)
        sv_pipe[i] <= sv_pipe[i-1];

      case (state)
        S_IDLE: begin
          if (start_go) begin
            state        <= S_RUN;
            step_r       <= step_sat;
            cnt          <= num_samples;
            continuous   <= (num_samples == '0);
            target_angle <= start_wrapped[ANGLE_W-1:0];
            angle_valid  <= 1'b1;
          end
        end
        S_RUN: begin
          if (angle_valid)
            cnt <= cnt - CNT_W'(1);
          // The angle on the bus during a stop cycle is still delivered; nothing follows it.
          if (last_angle || stop) begin
            state       <= S_DRAIN;
            angle_valid <= 1'b0;
            drain_cnt   <= DW'(CORDIC_LAT - 1);
          end else if (hold) begin
            angle_valid <= 1'b0;
          end else begin
            target_angle <= next_angle[ANGLE_W-1:0];
            angle_valid  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0)
            state <= S_DONE;
          else
            drain_cnt <= drain_cnt - DW'(1);
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
